// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared constants for the UART receive path (and a future transmitter):
// FSM state encoding, oversample rate, start-bit midpoint and the default
// frame width.
// No ports.
// -----------------------------------------------------------------------------
package uart_pkg;

  // Default frame width and oversampling.
  localparam int DATA_BITS = 8;
  localparam int OS_RATE   = 16;
  localparam int OS_MID    = 7;

  // FSM state encoding, kept as plain vectors for legacy tools.
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_START = 3'd1;
  localparam state_t ST_DATA  = 3'd2;
  localparam state_t ST_STOP  = 3'd3;
  localparam state_t ST_BREAK = 3'd4;

endpackage

// File: rtl/uart_rx_os16_if.sv
// -----------------------------------------------------------------------------
// uart_rx_os16_if
// Bundles the receiver's line-side inputs and byte-side outputs.
//   baud      : oversample square wave (one tick per rising edge)
//   rx        : raw serial line, idles high
//   data_out  : last good byte
//   valid     : one-clk pulse when data_out updates
//   frame_err : one-clk pulse when a stop bit samples low
//   busy      : receiver is not idle
// slave  : the receiver's view.
// master : the driver/consumer view.
// -----------------------------------------------------------------------------
interface uart_rx_os16_if #(
  parameter int DATA_BITS = uart_pkg::DATA_BITS
) ();

  logic                 baud;
  logic                 rx;
  logic [DATA_BITS-1:0] data_out;
  logic                 valid;
  logic                 frame_err;
  logic                 busy;

  modport slave  (input baud, rx, output data_out, valid, frame_err, busy);
  modport master (output baud, rx, input data_out, valid, frame_err, busy);

endinterface

// File: rtl/uart_rx_sync.sv
// -----------------------------------------------------------------------------
// uart_rx_sync
// Input conditioning for the UART: 2-flop synchronizer on the serial line and
// a rising-edge detector on the baud square wave.
//   clk      in  : system clock
//   rst_n    in  : asynchronous active-low reset
//   rx_i     in  : raw serial line
//   baud_i   in  : oversample square wave
//   rx_s_o   out : synchronized serial line
//   tick_o   out : single-clk enable on each baud rising edge
// -----------------------------------------------------------------------------
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic rx_i,
  input  logic baud_i,
  output logic rx_s_o,
  output logic tick_o
);

  logic rx_meta_q;
  logic rx_sync_q;
  logic baud_q;
  logic armed_q;

  // Synchronizer flops, baud history and post-reset arming flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      baud_q    <= 1'b0;
      armed_q   <= 1'b0;
    end else begin
      rx_meta_q <= rx_i;
      rx_sync_q <= rx_meta_q;
      baud_q    <= baud_i;
      armed_q   <= 1'b1;
    end
  end

  assign rx_s_o = rx_sync_q;
  // baud_q still holds its reset value on the first clk after release, so a
  // baud level that was already high would look like an edge there; armed_q
  // suppresses that spurious tick.
  assign tick_o = baud_i & ~baud_q & armed_q;

endmodule

// File: rtl/uart_rx_os16.sv
// -----------------------------------------------------------------------------
// uart_rx_os16
// 8N1 UART receiver driven by a 16x oversample baud signal. Delivers one byte
// per valid frame with a one-clk valid strobe and flags framing errors with a
// one-clk frame_err strobe. A line held low after a framing error parks in
// BREAK so that it produces a single error, not a stream.
//   clk    in  : system clock
//   rst_n  in  : asynchronous active-low reset
//   bus    slave modport of uart_rx_os16_if (baud, rx in;
//          data_out, valid, frame_err, busy out)
// -----------------------------------------------------------------------------
module uart_rx_os16 #(
  parameter int DATA_BITS = uart_pkg::DATA_BITS,
  parameter int OS_RATE   = uart_pkg::OS_RATE
) (
  input  logic           clk,
  input  logic           rst_n,
  uart_rx_os16_if.slave  bus
);

  import uart_pkg::*;

  localparam int OS_W = (OS_RATE > 1) ? $clog2(OS_RATE) : 1;
  localparam int BC_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [OS_W-1:0] OS_ZERO = OS_W'(0);
  localparam logic [OS_W-1:0] OS_ONE  = OS_W'(1);
  localparam logic [OS_W-1:0] OS_HALF = OS_W'(OS_MID);
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OS_RATE - 1);
  localparam logic [BC_W-1:0] BC_ZERO = BC_W'(0);
  localparam logic [BC_W-1:0] BC_ONE  = BC_W'(1);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(DATA_BITS - 1);

  logic rx_s;
  logic tick;

  state_t               state_q,    state_d;
  logic [OS_W-1:0]      os_cnt_q,   os_cnt_d;
  logic [BC_W-1:0]      bit_cnt_q,  bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q,    shift_d;
  logic [DATA_BITS-1:0] data_out_q, data_out_d;
  logic                 valid_q,    valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 busy_q,     busy_d;

  uart_rx_sync u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .rx_i   (bus.rx),
    .baud_i (bus.baud),
    .rx_s_o (rx_s),
    .tick_o (tick)
  );

  // Next-state logic for the frame FSM, counters and output strobes.
  always_comb begin
    state_d     = state_q;
    os_cnt_d    = os_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    data_out_d  = data_out_q;
    valid_d     = 1'b0;
    frame_err_d = 1'b0;

    if (tick) begin
      case (state_q)
        ST_IDLE: begin
          if (!rx_s) begin
            state_d  = ST_START;
            os_cnt_d = OS_ZERO;
          end else begin
            state_d = ST_IDLE;
          end
        end

        ST_START: begin
          if (os_cnt_q != OS_HALF) begin
            os_cnt_d = os_cnt_q + OS_ONE;
          end else if (!rx_s) begin
            // Start bit still low at its midpoint: frame is real.
            state_d   = ST_DATA;
            os_cnt_d  = OS_ZERO;
            bit_cnt_d = BC_ZERO;
          end else begin
            // Line recovered before midpoint: glitch, drop silently.
            state_d = ST_IDLE;
          end
        end

        ST_DATA: begin
          if (os_cnt_q != OS_LAST) begin
            os_cnt_d = os_cnt_q + OS_ONE;
          end else begin
            // LSB first: newest bit enters at the top and walks down to bit 0.
            shift_d  = {rx_s, shift_q[DATA_BITS-1:1]};
            os_cnt_d = OS_ZERO;
            if (bit_cnt_q == BC_LAST) begin
              state_d = ST_STOP;
            end else begin
              bit_cnt_d = bit_cnt_q + BC_ONE;
            end
          end
        end

        ST_STOP: begin
          if (os_cnt_q != OS_LAST) begin
            os_cnt_d = os_cnt_q + OS_ONE;
          end else if (rx_s) begin
            data_out_d = shift_q;
            valid_d    = 1'b1;
            state_d    = ST_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = ST_BREAK;
          end
        end

        ST_BREAK: begin
          if (rx_s) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_BREAK;
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end

    busy_d = (state_d != ST_IDLE);
  end

  // FSM, datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      os_cnt_q    <= OS_ZERO;
      bit_cnt_q   <= BC_ZERO;
      shift_q     <= {DATA_BITS{1'b0}};
      data_out_q  <= {DATA_BITS{1'b0}};
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      os_cnt_q    <= os_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      data_out_q  <= data_out_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.data_out  = data_out_q;
  assign bus.valid     = valid_q;
  assign bus.frame_err = frame_err_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_uart_rx_os16.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_os16
// Scoreboard bench for uart_rx_os16. The baud wave is sped up to one tick per
// 8 clk (128 clk per bit) so the whole run stays short; the receiver only sees
// ticks, so frame behaviour is unchanged.
// -----------------------------------------------------------------------------
module tb_uart_rx_os16;

  localparam int BIT_CLK  = 128;
  localparam int BAUD_HALF = 4;

  typedef struct {
    logic       err;
    logic [7:0] data;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_mis;
  int   n_valid;
  int   n_ferr;
  logic [7:0] last_good;
  exp_t sb_q[$];

  uart_rx_os16_if #(.DATA_BITS(8)) bus ();

  uart_rx_os16 #(.DATA_BITS(8), .OS_RATE(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running baud square wave, changed on the falling edge.
  initial begin
    bus.baud = 1'b0;
    forever begin
      repeat (BAUD_HALF) @(negedge clk);
      bus.baud = ~bus.baud;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_good(input logic [7:0] d);
    exp_t e;
    e.err  = 1'b0;
    e.data = d;
    sb_q.push_back(e);
    last_good = d;
  endtask

  task automatic expect_err();
    exp_t e;
    e.err  = 1'b1;
    e.data = last_good;
    sb_q.push_back(e);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    bus.rx = 1'b0;
    wait_clk(BIT_CLK);
    for (int i = 0; i < 8; i++) begin
      bus.rx = d[i];
      wait_clk(BIT_CLK);
    end
    bus.rx = stop_bit;
    wait_clk(BIT_CLK);
    bus.rx = 1'b1;
  endtask

  // Output monitor: every strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && (bus.valid === 1'b1 || bus.frame_err === 1'b1)) begin
      if (bus.valid === 1'b1) n_valid++;
      if (bus.frame_err === 1'b1) n_ferr++;
      if (sb_q.size() == 0) begin
        check("unexpected_pulse", {30'd0, bus.valid, bus.frame_err}, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("pulse_kind", {30'd0, bus.valid, bus.frame_err},
              e.err ? 32'd1 : 32'd2);
        check("data_out", {24'd0, bus.data_out}, {24'd0, e.data});
      end
    end
  end

  initial begin
    int v0;
    int f0;
    n_vec     = 0;
    n_mis     = 0;
    n_valid   = 0;
    n_ferr    = 0;
    last_good = 8'h00;
    bus.rx    = 1'b1;
    rst_n     = 1'b0;

    // Reset and idle.
    wait_clk(10);
    check("rst_data_out", {24'd0, bus.data_out}, 32'd0);
    check("rst_valid", {31'd0, bus.valid}, 32'd0);
    check("rst_frame_err", {31'd0, bus.frame_err}, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    rst_n = 1'b1;
    wait_clk(2000);
    check("idle_pulses", n_valid + n_ferr, 32'd0);
    check("idle_busy", {31'd0, bus.busy}, 32'd0);

    // Three good frames back to back.
    expect_good(8'hA5);
    send_frame(8'hA5, 1'b1);
    expect_good(8'h00);
    send_frame(8'h00, 1'b1);
    expect_good(8'hFF);
    send_frame(8'hFF, 1'b1);
    wait_clk(2 * BIT_CLK);
    check("good_valids", n_valid, 32'd3);
    check("good_ferrs", n_ferr, 32'd0);

    // Start-bit glitch shorter than half a bit.
    v0 = n_valid;
    f0 = n_ferr;
    bus.rx = 1'b0;
    wait_clk(30);
    bus.rx = 1'b1;
    wait_clk(2 * BIT_CLK);
    check("glitch_pulses", (n_valid - v0) + (n_ferr - f0), 32'd0);
    check("glitch_busy", {31'd0, bus.busy}, 32'd0);

    // Framing error: stop bit low.
    v0 = n_valid;
    f0 = n_ferr;
    expect_err();
    send_frame(8'h3C, 1'b0);
    wait_clk(2 * BIT_CLK);
    check("ferr_count", n_ferr - f0, 32'd1);
    check("ferr_no_valid", n_valid - v0, 32'd0);
    check("ferr_hold_data", {24'd0, bus.data_out}, {24'd0, last_good});
    check("ferr_busy", {31'd0, bus.busy}, 32'd0);

    // Break: line low for 20 bit times gives a single error.
    v0 = n_valid;
    f0 = n_ferr;
    expect_err();
    bus.rx = 1'b0;
    wait_clk(20 * BIT_CLK);
    check("break_one_err", n_ferr - f0, 32'd1);
    check("break_busy", {31'd0, bus.busy}, 32'd1);
    bus.rx = 1'b1;
    wait_clk(2 * BIT_CLK);
    check("break_exit_busy", {31'd0, bus.busy}, 32'd0);
    expect_good(8'h55);
    send_frame(8'h55, 1'b1);
    wait_clk(BIT_CLK);
    check("break_recover", n_valid - v0, 32'd1);

    // Reset in the middle of 0x81 after four data bits.
    bus.rx = 1'b0;
    wait_clk(BIT_CLK);
    for (int i = 0; i < 4; i++) begin
      bus.rx = (i == 0) ? 1'b1 : 1'b0;
      wait_clk(BIT_CLK);
    end
    check("mid_busy", {31'd0, bus.busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_data_out", {24'd0, bus.data_out}, 32'd0);
    check("mid_rst_valid", {31'd0, bus.valid}, 32'd0);
    check("mid_rst_frame_err", {31'd0, bus.frame_err}, 32'd0);
    check("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
    last_good = 8'h00;
    bus.rx = 1'b1;
    wait_clk(10);
    rst_n = 1'b1;
    wait_clk(2 * BIT_CLK);
    expect_good(8'h81);
    send_frame(8'h81, 1'b1);
    wait_clk(BIT_CLK);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 5000 && sb_q.size() != 0; i++) begin
      @(negedge clk);
    end
    check("sb_drain", sb_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
